// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding.
// Holds the decoded instruction for one cycle, inserts bubbles on flush or load-use stall,
// and selects the ALU operands from the register, EX/MEM or MEM/WB results.
module id_ex_stage #(
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      ID_ALUOperation,
    input  logic [4:0]      ID_shamt,
    input  logic [WORD-1:0] ID_ReadData1,
    input  logic [WORD-1:0] ID_ReadData2,
    input  logic [WORD-1:0] ID_Immediate,
    input  logic [4:0]      ID_rs,
    input  logic [4:0]      ID_rt,
    input  logic [4:0]      ID_rd,
    input  logic            ID_ALUSrc,
    input  logic            ID_RegDst,
    input  logic            ID_RegWrite,
    input  logic            ID_MemRead,
    input  logic            ID_MemWrite,
    input  logic            ID_MemtoReg,
    input  logic            Flush,
    input  logic            EXMEM_RegWrite,
    input  logic [4:0]      EXMEM_WriteReg,
    input  logic [WORD-1:0] EXMEM_ALUResult,
    input  logic            MEMWB_RegWrite,
    input  logic [4:0]      MEMWB_WriteReg,
    input  logic [WORD-1:0] MEMWB_WriteData,
    output logic [3:0]      EX_ALUOperation,
    output logic [4:0]      EX_shamt,
    output logic [WORD-1:0] EX_A,
    output logic [WORD-1:0] EX_B,
    output logic [WORD-1:0] EX_StoreData,
    output logic [4:0]      EX_WriteReg,
    output logic            EX_RegWrite,
    output logic            EX_MemRead,
    output logic            EX_MemWrite,
    output logic            EX_MemtoReg,
    output logic            Stall
);

    logic [3:0]      aluop_q;
    logic [4:0]      shamt_q;
    logic [WORD-1:0] readdata1_q;
    logic [WORD-1:0] readdata2_q;
    logic [WORD-1:0] immediate_q;
    logic [4:0]      rs_q;
    logic [4:0]      rt_q;
    logic [4:0]      rd_q;
    logic            alusrc_q;
    logic            regdst_q;
    logic            regwrite_q;
    logic            memread_q;
    logic            memwrite_q;
    logic            memtoreg_q;

    logic [4:0]      writereg;
    logic            stall;
    logic [WORD-1:0] fwda;
    logic [WORD-1:0] fwdb;

    // ID/EX register: reset, flush and stall all load an all-zero bubble, otherwise capture decode
    always_ff @(posedge clk) begin
        if (reset || Flush || stall) begin
            aluop_q     <= 4'b0000;
            shamt_q     <= 5'd0;
            readdata1_q <= '0;
            readdata2_q <= '0;
            immediate_q <= '0;
            rs_q        <= 5'd0;
            rt_q        <= 5'd0;
            rd_q        <= 5'd0;
            alusrc_q    <= 1'b0;
            regdst_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
        end else begin
            aluop_q     <= ID_ALUOperation;
            shamt_q     <= ID_shamt;
            readdata1_q <= ID_ReadData1;
            readdata2_q <= ID_ReadData2;
            immediate_q <= ID_Immediate;
            rs_q        <= ID_rs;
            rt_q        <= ID_rt;
            rd_q        <= ID_rd;
            alusrc_q    <= ID_ALUSrc;
            regdst_q    <= ID_RegDst;
            regwrite_q  <= ID_RegWrite;
            memread_q   <= ID_MemRead;
            memwrite_q  <= ID_MemWrite;
            memtoreg_q  <= ID_MemtoReg;
        end
    end

    // Destination select and load-use detection against the instruction currently in decode
    always_comb begin
        writereg = regdst_q ? rd_q : rt_q;
        stall    = 1'b0;
        if (memread_q && (writereg != 5'd0) &&
            ((writereg == ID_rs) || (writereg == ID_rt))) begin
            stall = 1'b1;
        end
    end

    // Operand forwarding: EX/MEM wins over MEM/WB, and $zero is never forwarded
    always_comb begin
        fwda = readdata1_q;
        fwdb = readdata2_q;
        if (EXMEM_RegWrite && (EXMEM_WriteReg != 5'd0) && (EXMEM_WriteReg == rs_q)) begin
            fwda = EXMEM_ALUResult;
        end else if (MEMWB_RegWrite && (MEMWB_WriteReg != 5'd0) && (MEMWB_WriteReg == rs_q)) begin
            fwda = MEMWB_WriteData;
        end
        if (EXMEM_RegWrite && (EXMEM_WriteReg != 5'd0) && (EXMEM_WriteReg == rt_q)) begin
            fwdb = EXMEM_ALUResult;
        end else if (MEMWB_RegWrite && (MEMWB_WriteReg != 5'd0) && (MEMWB_WriteReg == rt_q)) begin
            fwdb = MEMWB_WriteData;
        end
    end

    // Output drive: operand B takes the immediate for ALUSrc, store data is always the forwarded rt
    always_comb begin
        EX_ALUOperation = aluop_q;
        EX_shamt        = shamt_q;
        EX_A            = fwda;
        EX_B            = alusrc_q ? immediate_q : fwdb;
        EX_StoreData    = fwdb;
        EX_WriteReg     = writereg;
        EX_RegWrite     = regwrite_q;
        EX_MemRead      = memread_q;
        EX_MemWrite     = memwrite_q;
        EX_MemtoReg     = memtoreg_q;
        Stall           = stall;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios followed by
// randomized traffic compared against a transaction-level model of the EX slot.
module tb_id_ex_stage;

    typedef struct packed {
        logic [3:0]  aluOp;
        logic [4:0]  shamt;
        logic [31:0] readData1;
        logic [31:0] readData2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        aluSrc;
        logic        regDst;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        memToReg;
    } instr_t;

    logic        clk = 1'b0;
    logic        resetIn = 1'b1;
    logic        flush = 1'b0;
    instr_t      cur = '0;
    logic        exmemRegWrite = 1'b0;
    logic [4:0]  exmemWriteReg = 5'd0;
    logic [31:0] exmemResult = '0;
    logic        memwbRegWrite = 1'b0;
    logic [4:0]  memwbWriteReg = 5'd0;
    logic [31:0] memwbData = '0;

    logic [3:0]  exAluOp;
    logic [4:0]  exShamt;
    logic [31:0] exA;
    logic [31:0] exB;
    logic [31:0] exStoreData;
    logic [4:0]  exWriteReg;
    logic        exRegWrite;
    logic        exMemRead;
    logic        exMemWrite;
    logic        exMemToReg;
    logic        stallOut;

    instr_t ex = '0;
    int     assertCount = 0;
    int     failCount = 0;

    id_ex_stage #(.WORD(32)) dut (
        .clk             (clk),
        .reset           (resetIn),
        .ID_ALUOperation (cur.aluOp),
        .ID_shamt        (cur.shamt),
        .ID_ReadData1    (cur.readData1),
        .ID_ReadData2    (cur.readData2),
        .ID_Immediate    (cur.imm),
        .ID_rs           (cur.rs),
        .ID_rt           (cur.rt),
        .ID_rd           (cur.rd),
        .ID_ALUSrc       (cur.aluSrc),
        .ID_RegDst       (cur.regDst),
        .ID_RegWrite     (cur.regWrite),
        .ID_MemRead      (cur.memRead),
        .ID_MemWrite     (cur.memWrite),
        .ID_MemtoReg     (cur.memToReg),
        .Flush           (flush),
        .EXMEM_RegWrite  (exmemRegWrite),
        .EXMEM_WriteReg  (exmemWriteReg),
        .EXMEM_ALUResult (exmemResult),
        .MEMWB_RegWrite  (memwbRegWrite),
        .MEMWB_WriteReg  (memwbWriteReg),
        .MEMWB_WriteData (memwbData),
        .EX_ALUOperation (exAluOp),
        .EX_shamt        (exShamt),
        .EX_A            (exA),
        .EX_B            (exB),
        .EX_StoreData    (exStoreData),
        .EX_WriteReg     (exWriteReg),
        .EX_RegWrite     (exRegWrite),
        .EX_MemRead      (exMemRead),
        .EX_MemWrite     (exMemWrite),
        .EX_MemtoReg     (exMemToReg),
        .Stall           (stallOut)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelOperand(input logic [4:0] r, input logic [31:0] regVal);
        if (r == 5'd0) return regVal;
        if (exmemRegWrite && exmemWriteReg == r) return exmemResult;
        if (memwbRegWrite && memwbWriteReg == r) return memwbData;
        return regVal;
    endfunction

    function automatic logic [4:0] modelDest(input instr_t i);
        return i.regDst ? i.rd : i.rt;
    endfunction

    function automatic logic modelStall();
        logic [4:0] d;
        d = modelDest(ex);
        return ex.memRead && d != 5'd0 && (d == cur.rs || d == cur.rt);
    endfunction

    task automatic checkAll();
        logic [31:0] opB;
        opB = modelOperand(ex.rt, ex.readData2);
        checkOutput("aluOp",     {28'd0, exAluOp},    {28'd0, ex.aluOp});
        checkOutput("shamt",     {27'd0, exShamt},    {27'd0, ex.shamt});
        checkOutput("opA",       exA,                 modelOperand(ex.rs, ex.readData1));
        checkOutput("opB",       exB,                 ex.aluSrc ? ex.imm : opB);
        checkOutput("storeData", exStoreData,         opB);
        checkOutput("writeReg",  {27'd0, exWriteReg}, {27'd0, modelDest(ex)});
        checkOutput("regWrite",  {31'd0, exRegWrite}, {31'd0, ex.regWrite});
        checkOutput("memRead",   {31'd0, exMemRead},  {31'd0, ex.memRead});
        checkOutput("memWrite",  {31'd0, exMemWrite}, {31'd0, ex.memWrite});
        checkOutput("memToReg",  {31'd0, exMemToReg}, {31'd0, ex.memToReg});
        checkOutput("stall",     {31'd0, stallOut},   {31'd0, modelStall()});
    endtask

    // One cycle: check settled outputs mid-cycle, clock the edge, then advance the model
    task automatic applyStimulus();
        logic squash;
        @(negedge clk);
        checkAll();
        squash = resetIn || flush || modelStall();
        @(posedge clk);
        #1;
        ex = squash ? instr_t'('0) : cur;
    endtask

    function automatic instr_t makeAdd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [31:0] a, input logic [31:0] b);
        instr_t i;
        i = '0;
        i.aluOp = 4'b0011;
        i.rs = rs; i.rt = rt; i.rd = rd;
        i.readData1 = a; i.readData2 = b;
        i.regDst = 1'b1; i.regWrite = 1'b1;
        return i;
    endfunction

    function automatic instr_t makeLw(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [31:0] a, input logic [31:0] imm);
        instr_t i;
        i = '0;
        i.aluOp = 4'b0010;
        i.rs = rs; i.rt = rt;
        i.readData1 = a; i.imm = imm;
        i.aluSrc = 1'b1; i.regWrite = 1'b1; i.memRead = 1'b1; i.memToReg = 1'b1;
        return i;
    endfunction

    // Stimulus: startup reset, directed scenarios, then randomized traffic
    initial begin
        repeat (2) @(posedge clk);
        #1;
        ex = '0;
        resetIn = 1'b0;

        // Reset state
        checkOutput("resetStall", {31'd0, stallOut}, 32'd0);
        checkOutput("resetA", exA, 32'd0);
        applyStimulus();

        // add $3,$1,$2
        cur = makeAdd(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        applyStimulus();
        checkOutput("addA", exA, 32'd5);
        checkOutput("addB", exB, 32'd7);
        checkOutput("addWriteReg", {27'd0, exWriteReg}, 32'd3);
        checkOutput("addRegWrite", {31'd0, exRegWrite}, 32'd1);
        checkOutput("addAluOp", {28'd0, exAluOp}, 32'd3);

        // Forwarding priority for rs=$4
        cur = makeAdd(5'd4, 5'd6, 5'd7, 32'd1, 32'd9);
        applyStimulus();
        cur = '0;
        exmemRegWrite = 1'b1; exmemWriteReg = 5'd4; exmemResult = 32'h10;
        memwbRegWrite = 1'b1; memwbWriteReg = 5'd4; memwbData = 32'h20;
        #1;
        checkOutput("fwdExMem", exA, 32'h10);
        exmemRegWrite = 1'b0;
        #1;
        checkOutput("fwdMemWb", exA, 32'h20);
        applyStimulus();
        memwbRegWrite = 1'b0;

        // No forwarding into $zero
        cur = makeAdd(5'd0, 5'd6, 5'd7, 32'd0, 32'd9);
        applyStimulus();
        exmemRegWrite = 1'b1; exmemWriteReg = 5'd0; exmemResult = 32'hFFFF_FFFF;
        #1;
        checkOutput("zeroNoFwd", exA, 32'd0);
        applyStimulus();
        exmemRegWrite = 1'b0;

        // Load-use stall lasts one cycle, then the held instruction loads
        cur = makeLw(5'd1, 5'd5, 32'h100, 32'd4);
        applyStimulus();
        cur = makeAdd(5'd5, 5'd2, 5'd8, 32'h11, 32'h22);
        #1;
        checkOutput("loadUseStall", {31'd0, stallOut}, 32'd1);
        applyStimulus();
        checkOutput("bubbleMemRead", {31'd0, exMemRead}, 32'd0);
        checkOutput("bubbleRegWrite", {31'd0, exRegWrite}, 32'd0);
        checkOutput("stallReleased", {31'd0, stallOut}, 32'd0);
        applyStimulus();
        checkOutput("heldWriteReg", {27'd0, exWriteReg}, 32'd8);
        checkOutput("heldRegWrite", {31'd0, exRegWrite}, 32'd1);
        checkOutput("heldA", exA, 32'h11);

        // Flush squashes the decoding instruction
        cur = makeAdd(5'd1, 5'd2, 5'd9, 32'd3, 32'd4);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        checkOutput("flushRegWrite", {31'd0, exRegWrite}, 32'd0);
        checkOutput("flushWriteReg", {27'd0, exWriteReg}, 32'd0);
        checkOutput("flushMemRead", {31'd0, exMemRead}, 32'd0);

        // Reset during a stall discards both instructions
        cur = makeLw(5'd1, 5'd5, 32'h200, 32'd8);
        applyStimulus();
        cur = makeAdd(5'd2, 5'd5, 5'd8, 32'h33, 32'h44);
        #1;
        checkOutput("preResetStall", {31'd0, stallOut}, 32'd1);
        resetIn = 1'b1;
        applyStimulus();
        resetIn = 1'b0;
        checkOutput("rstA", exA, 32'd0);
        checkOutput("rstB", exB, 32'd0);
        checkOutput("rstWriteReg", {27'd0, exWriteReg}, 32'd0);
        checkOutput("rstRegWrite", {31'd0, exRegWrite}, 32'd0);
        checkOutput("rstStall", {31'd0, stallOut}, 32'd0);

        // Randomized traffic with small register numbers to provoke hazards and forwarding
        for (int n = 0; n < 400; n++) begin
            cur.aluOp     = 4'($urandom);
            cur.shamt     = 5'($urandom);
            cur.readData1 = $urandom;
            cur.readData2 = $urandom;
            cur.imm       = $urandom;
            cur.rs        = 5'($urandom_range(0, 7));
            cur.rt        = 5'($urandom_range(0, 7));
            cur.rd        = 5'($urandom_range(0, 7));
            cur.aluSrc    = 1'($urandom);
            cur.regDst    = 1'($urandom);
            cur.regWrite  = 1'($urandom);
            cur.memRead   = ($urandom_range(0, 9) < 3);
            cur.memWrite  = 1'($urandom);
            cur.memToReg  = 1'($urandom);
            flush         = ($urandom_range(0, 9) == 0);
            resetIn       = ($urandom_range(0, 29) == 0);
            exmemRegWrite = 1'($urandom);
            exmemWriteReg = 5'($urandom_range(0, 7));
            exmemResult   = $urandom;
            memwbRegWrite = 1'($urandom);
            memwbWriteReg = 5'($urandom_range(0, 7));
            memwbData     = $urandom;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
